// File: rtl/qeciphy_gt_status_monitor_if.sv
// GT status monitor bundle: raw GT flags and sequencer handshake in,
// qualified flags, re-initialisation request and fault log out.
// The master side drives the raw flags (GT wrapper / sequencer side);
// the slave side is the status monitor itself.
interface qeciphy_gt_status_monitor_if;

  logic       gt_power_good_raw_i;
  logic       gt_tx_rst_done_raw_i;
  logic       gt_rx_rst_done_raw_i;
  logic       rst_done_i;
  logic       fault_clr_i;

  logic       gt_power_good_o;
  logic       gt_tx_rst_done_o;
  logic       gt_rx_rst_done_o;
  logic       reinit_req_o;
  logic       link_up_o;
  logic [1:0] fault_cause_o;
  logic [7:0] fault_count_o;

  modport master (
    output gt_power_good_raw_i,
    output gt_tx_rst_done_raw_i,
    output gt_rx_rst_done_raw_i,
    output rst_done_i,
    output fault_clr_i,
    input  gt_power_good_o,
    input  gt_tx_rst_done_o,
    input  gt_rx_rst_done_o,
    input  reinit_req_o,
    input  link_up_o,
    input  fault_cause_o,
    input  fault_count_o
  );

  modport slave (
    input  gt_power_good_raw_i,
    input  gt_tx_rst_done_raw_i,
    input  gt_rx_rst_done_raw_i,
    input  rst_done_i,
    input  fault_clr_i,
    output gt_power_good_o,
    output gt_tx_rst_done_o,
    output gt_rx_rst_done_o,
    output reinit_req_o,
    output link_up_o,
    output fault_cause_o,
    output fault_count_o
  );

endinterface

// File: rtl/qeciphy_gt_status_monitor.sv
// GT status monitor.
// Debounces the three synchronised GT status flags, supervises link
// bring-up with a watchdog, and watches for loss of GT status once the
// reset sequencer reports completion. Any timeout or status loss pulses
// reinit_req for HOLD_CYCLES cycles so the sequencer restarts from scratch,
// and the cause is kept in a small sticky fault log.
module qeciphy_gt_status_monitor #(
  parameter int FILTER_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 65536,
  parameter int HOLD_CYCLES    = 64
) (
  input logic                         axis_clk_i,
  input logic                         axis_rst_i,
  qeciphy_gt_status_monitor_if.slave  gt_if
);

  // Counter widths: just wide enough for (parameter - 1), never below 1 bit.
  localparam int FCW = (FILTER_CYCLES  > 1) ? $clog2(FILTER_CYCLES)  : 1;
  localparam int TW  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int HW  = (HOLD_CYCLES    > 1) ? $clog2(HOLD_CYCLES)    : 1;

  localparam logic [FCW-1:0] FILT_MAX  = FCW'(FILTER_CYCLES - 1);
  localparam logic [TW-1:0]  TIMER_MAX = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [HW-1:0]  HOLD_MAX  = HW'(HOLD_CYCLES - 1);

  // Flag positions inside the filter vectors.
  localparam int FLAG_PG = 0;
  localparam int FLAG_TX = 1;
  localparam int FLAG_RX = 2;

  localparam logic [1:0] CAUSE_TIMEOUT = 2'b01;
  localparam logic [1:0] CAUSE_LOSS    = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_DONE,
    ST_RUNNING,
    ST_REINIT
  } state_t;

  logic [2:0]          rawFlags;
  logic [2:0][FCW-1:0] filtCnt_q;
  logic [2:0][FCW-1:0] filtCnt_d;
  logic [2:0]          filtFlag_q;
  logic [2:0]          filtFlag_d;

  state_t              state_q;
  logic [TW-1:0]       timer_q;
  logic [HW-1:0]       hold_q;
  logic                linkUp_q;
  logic                reinitReq_q;
  logic [1:0]          faultCause_q;
  logic [7:0]          faultCount_q;
  logic [7:0]          faultCount_d;
  logic                allFlagsUp;

  assign rawFlags = {gt_if.gt_rx_rst_done_raw_i,
                     gt_if.gt_tx_rst_done_raw_i,
                     gt_if.gt_power_good_raw_i};

  // Filter next-state: a low sample clears at once, a high run has to last
  // FILTER_CYCLES edges before the filtered flag is believed.
  always_comb begin
    filtCnt_d  = filtCnt_q;
    filtFlag_d = filtFlag_q;
    for (int i = 0; i < 3; i++) begin
      if (!rawFlags[i]) begin
        filtCnt_d[i]  = '0;
        filtFlag_d[i] = 1'b0;
      end else if (filtCnt_q[i] == FILT_MAX) begin
        filtFlag_d[i] = 1'b1;
      end else begin
        filtCnt_d[i] = filtCnt_q[i] + 1'b1;
      end
    end
  end

  // Filter registers; they keep running in every FSM state.
  always_ff @(posedge axis_clk_i) begin
    if (axis_rst_i) begin
      filtCnt_q  <= '0;
      filtFlag_q <= '0;
    end else begin
      filtCnt_q  <= filtCnt_d;
      filtFlag_q <= filtFlag_d;
    end
  end

  // Saturating increment used whenever a fault is logged.
  always_comb begin
    faultCount_d = (faultCount_q == 8'hFF) ? 8'hFF : faultCount_q + 8'd1;
  end

  assign allFlagsUp = &filtFlag_q;

  // Bring-up supervisor: state, watchdog, re-init hold and fault log.
  // Outputs are registered alongside each transition so nothing from the
  // inputs reaches the outputs combinationally.
  always_ff @(posedge axis_clk_i) begin
    if (axis_rst_i) begin
      state_q      <= ST_IDLE;
      timer_q      <= '0;
      hold_q       <= '0;
      linkUp_q     <= 1'b0;
      reinitReq_q  <= 1'b0;
      faultCause_q <= 2'b00;
      faultCount_q <= 8'd0;
    end else begin
      // A clear request is overridden by a fault logged on the same edge,
      // because the later non-blocking assignment below wins.
      if (gt_if.fault_clr_i) begin
        faultCause_q <= 2'b00;
      end

      case (state_q)
        ST_IDLE: begin
          if (filtFlag_q[FLAG_PG]) begin
            state_q <= ST_WAIT_DONE;
            timer_q <= '0;
          end
        end

        ST_WAIT_DONE: begin
          if (!filtFlag_q[FLAG_PG]) begin
            state_q <= ST_IDLE;
          end else if (gt_if.rst_done_i) begin
            state_q  <= ST_RUNNING;
            linkUp_q <= 1'b1;
          end else if (timer_q == TIMER_MAX) begin
            state_q      <= ST_REINIT;
            reinitReq_q  <= 1'b1;
            hold_q       <= '0;
            faultCause_q <= CAUSE_TIMEOUT;
            faultCount_q <= faultCount_d;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end

        ST_RUNNING: begin
          if (!allFlagsUp) begin
            state_q      <= ST_REINIT;
            linkUp_q     <= 1'b0;
            reinitReq_q  <= 1'b1;
            hold_q       <= '0;
            faultCause_q <= CAUSE_LOSS;
            faultCount_q <= faultCount_d;
          end else if (!gt_if.rst_done_i) begin
            // Sequencer was reset from elsewhere: wait for it again, no fault.
            state_q  <= ST_WAIT_DONE;
            linkUp_q <= 1'b0;
            timer_q  <= '0;
          end
        end

        ST_REINIT: begin
          if (hold_q == HOLD_MAX) begin
            state_q     <= ST_IDLE;
            reinitReq_q <= 1'b0;
          end else begin
            hold_q <= hold_q + 1'b1;
          end
        end

        default: begin
          state_q     <= ST_IDLE;
          linkUp_q    <= 1'b0;
          reinitReq_q <= 1'b0;
        end
      endcase
    end
  end

  assign gt_if.gt_power_good_o  = filtFlag_q[FLAG_PG];
  assign gt_if.gt_tx_rst_done_o = filtFlag_q[FLAG_TX];
  assign gt_if.gt_rx_rst_done_o = filtFlag_q[FLAG_RX];
  assign gt_if.reinit_req_o     = reinitReq_q;
  assign gt_if.link_up_o        = linkUp_q;
  assign gt_if.fault_cause_o    = faultCause_q;
  assign gt_if.fault_count_o    = faultCount_q;

endmodule

// File: tb/tb_qeciphy_gt_status_monitor.sv
// Testbench for qeciphy_gt_status_monitor.
// Stimulus is driven on the falling edge; the reference model predicts the
// outputs after the next rising edge and queues them. A separate monitor
// pops and compares once that edge has happened.
module tb_qeciphy_gt_status_monitor;

  localparam int FILTER_CYCLES  = 16;
  localparam int TIMEOUT_CYCLES = 100;
  localparam int HOLD_CYCLES    = 64;

  localparam int M_IDLE    = 0;
  localparam int M_WAITING = 1;
  localparam int M_LINKED  = 2;
  localparam int M_REINIT  = 3;

  typedef struct {
    int         cyc;
    logic       pg;
    logic       tx;
    logic       rx;
    logic       reinit;
    logic       link;
    logic [1:0] cause;
    logic [7:0] count;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   edgeCnt = 0;
  int   checks  = 0;
  int   errors  = 0;
  int   pushed  = 0;
  int   popped  = 0;
  exp_t sbQ[$];

  // Reference model state
  int runLen[3];
  int mode;
  int waitElapsed;
  int holdLeft;
  int mCause;
  int mCount;
  int faultsRaised;
  bit mFilt[3];

  qeciphy_gt_status_monitor_if gtIf ();

  qeciphy_gt_status_monitor #(
    .FILTER_CYCLES (FILTER_CYCLES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .HOLD_CYCLES   (HOLD_CYCLES)
  ) dut (
    .axis_clk_i(clk),
    .axis_rst_i(rst),
    .gt_if     (gtIf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edgeCnt <= edgeCnt + 1;

  task automatic raiseFault(input int c);
    mode     = M_REINIT;
    holdLeft = HOLD_CYCLES;
    mCause   = c;
    if (mCount < 255) mCount++;
    faultsRaised++;
  endtask

  // One clock edge of the behavioural model, using inputs sampled at that edge.
  task automatic modelStep(input bit r, input bit pg, input bit tx, input bit rx,
                           input bit rd, input bit clr);
    bit oldPg;
    bit allUp;
    bit raw[3];
    if (r) begin
      for (int i = 0; i < 3; i++) begin runLen[i] = 0; mFilt[i] = 0; end
      mode = M_IDLE; waitElapsed = 0; holdLeft = 0; mCause = 0; mCount = 0;
      return;
    end
    oldPg = mFilt[0];
    allUp = mFilt[0] && mFilt[1] && mFilt[2];
    raw[0] = pg; raw[1] = tx; raw[2] = rx;
    for (int i = 0; i < 3; i++) begin
      runLen[i] = raw[i] ? runLen[i] + 1 : 0;
      mFilt[i]  = (runLen[i] >= FILTER_CYCLES);
    end
    if (clr) mCause = 0;
    case (mode)
      M_IDLE: if (oldPg) begin mode = M_WAITING; waitElapsed = 0; end
      M_WAITING: begin
        if (!oldPg) mode = M_IDLE;
        else if (rd) mode = M_LINKED;
        else begin
          waitElapsed++;
          if (waitElapsed == TIMEOUT_CYCLES) raiseFault(1);
        end
      end
      M_LINKED: begin
        if (!allUp) raiseFault(2);
        else if (!rd) begin mode = M_WAITING; waitElapsed = 0; end
      end
      default: begin
        holdLeft--;
        if (holdLeft == 0) mode = M_IDLE;
      end
    endcase
  endtask

  // Drive one cycle of inputs and queue what the model expects after the edge.
  task automatic applyStimulus(input bit r, input bit pg, input bit tx, input bit rx,
                               input bit rd, input bit clr);
    exp_t e;
    @(negedge clk);
    rst = r;
    gtIf.gt_power_good_raw_i  = pg;
    gtIf.gt_tx_rst_done_raw_i = tx;
    gtIf.gt_rx_rst_done_raw_i = rx;
    gtIf.rst_done_i           = rd;
    gtIf.fault_clr_i          = clr;
    modelStep(r, pg, tx, rx, rd, clr);
    e.cyc    = edgeCnt + 1;
    e.pg     = mFilt[0];
    e.tx     = mFilt[1];
    e.rx     = mFilt[2];
    e.reinit = (mode == M_REINIT);
    e.link   = (mode == M_LINKED);
    e.cause  = 2'(mCause);
    e.count  = 8'(mCount);
    sbQ.push_back(e);
    pushed++;
  endtask

  task automatic repeatStimulus(input int n, input bit r, input bit pg, input bit tx,
                                input bit rx, input bit rd, input bit clr);
    for (int k = 0; k < n; k++) applyStimulus(r, pg, tx, rx, rd, clr);
  endtask

  task automatic checkOutput(input string name, input int cyc,
                             input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
    end
  endtask

  // Monitor: compare every queued expectation once its edge has occurred.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sbQ.size() > 0 && sbQ[0].cyc == edgeCnt) begin
        e = sbQ.pop_front();
        popped++;
        checkOutput("power_good", e.cyc, {7'd0, gtIf.gt_power_good_o},  {7'd0, e.pg});
        checkOutput("tx_done",    e.cyc, {7'd0, gtIf.gt_tx_rst_done_o}, {7'd0, e.tx});
        checkOutput("rx_done",    e.cyc, {7'd0, gtIf.gt_rx_rst_done_o}, {7'd0, e.rx});
        checkOutput("reinit_req", e.cyc, {7'd0, gtIf.reinit_req_o},     {7'd0, e.reinit});
        checkOutput("link_up",    e.cyc, {7'd0, gtIf.link_up_o},        {7'd0, e.link});
        checkOutput("fault_cause", e.cyc, {6'd0, gtIf.fault_cause_o},   {6'd0, e.cause});
        checkOutput("fault_count", e.cyc, gtIf.fault_count_o,           e.count);
      end
    end
  end

  // Global time limit so the bench always ends.
  initial begin
    #5_000_000;
    errors++;
    $display("[TB] FAIL watchdog cyc=%0d got=running exp=finished", edgeCnt);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "[TB] time limit reached");
  end

  initial begin
    bit flagVal[4];
    int segLeft[4];
    bit clr;
    int guard;

    gtIf.gt_power_good_raw_i  = 1'b0;
    gtIf.gt_tx_rst_done_raw_i = 1'b0;
    gtIf.gt_rx_rst_done_raw_i = 1'b0;
    gtIf.rst_done_i           = 1'b0;
    gtIf.fault_clr_i          = 1'b0;
    faultsRaised = 0;

    $display("[TB] reset");
    repeat (3) applyStimulus(1, 0, 0, 0, 0, 0);

    $display("[TB] filter rise, glitch and watchdog timeout");
    repeatStimulus(10, 0, 1, 1, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    repeatStimulus(20, 0, 1, 1, 1, 0, 0);
    repeatStimulus(TIMEOUT_CYCLES + HOLD_CYCLES, 0, 1, 1, 1, 0, 0);

    $display("[TB] bring-up then rx loss");
    guard = 0;
    while (mode != M_WAITING && guard < 500) begin
      applyStimulus(0, 1, 1, 1, 0, 0); guard++;
    end
    repeatStimulus(5, 0, 1, 1, 1, 1, 0);
    applyStimulus(0, 1, 1, 0, 1, 0);
    repeatStimulus(HOLD_CYCLES + 5, 0, 1, 1, 1, 0, 0);

    $display("[TB] external sequencer reset while running");
    repeatStimulus(20, 0, 1, 1, 1, 0, 0);
    repeatStimulus(5, 0, 1, 1, 1, 1, 0);
    repeatStimulus(5, 0, 1, 1, 1, 0, 0);
    repeatStimulus(3, 0, 1, 1, 1, 1, 0);

    $display("[TB] fault clear colliding with timeout");
    repeatStimulus(3, 0, 1, 1, 1, 0, 0);
    guard = 0;
    while (!(mode == M_REINIT) && guard < 500) begin
      clr = (mode == M_WAITING) && (waitElapsed == TIMEOUT_CYCLES - 1);
      applyStimulus(0, 1, 1, 1, 0, clr); guard++;
    end
    repeatStimulus(HOLD_CYCLES + 2, 0, 1, 1, 1, 0, 0);
    applyStimulus(0, 1, 1, 1, 0, 1);
    repeatStimulus(3, 0, 1, 1, 1, 0, 0);

    $display("[TB] fault counter saturation");
    guard = 0;
    while (faultsRaised < 265 && guard < 30000) begin
      applyStimulus(0, 1, 0, 1, 1, 0); guard++;
    end
    guard = 0;
    while (!(mode == M_REINIT && holdLeft == HOLD_CYCLES - 10) && guard < 500) begin
      applyStimulus(0, 1, 0, 1, 1, 0); guard++;
    end
    applyStimulus(1, 1, 0, 1, 1, 0);
    repeatStimulus(3, 0, 0, 0, 0, 0, 0);

    $display("[TB] randomized segments");
    for (int i = 0; i < 4; i++) begin flagVal[i] = 0; segLeft[i] = 0; end
    for (int k = 0; k < 4000; k++) begin
      for (int i = 0; i < 4; i++) begin
        if (segLeft[i] == 0) begin
          flagVal[i] = ($urandom_range(0, 3) != 0);
          segLeft[i] = (i == 3) ? $urandom_range(1, 150) : $urandom_range(1, 40);
        end
        segLeft[i]--;
      end
      applyStimulus(($urandom_range(0, 1999) == 0), flagVal[0], flagVal[1], flagVal[2],
                    flagVal[3], ($urandom_range(0, 49) == 0));
    end

    repeat (3) @(negedge clk);
    checkOutput("scoreboard_drain", edgeCnt, 8'(sbQ.size()), 8'd0);
    checkOutput("scoreboard_pops", edgeCnt, 8'(pushed - popped), 8'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
